mac_operand_feeder: RTL and testbench
=====================================

// Module: mac_operand_feeder
// PURPOSE
//  Upstream stage of the FP16 multiply-accumulate processing unit.
//  - Holds one K-element vector pair (A[i], B[i]) in a local operand buffer.
//  - On command, streams the pairs into the processing unit one at a time, using its start/ready handshake.
//  - Reports busy/done to the tile controller.
// PARAMETERS
//  DEPTH   8   max vector length K (operand buffer entries), >=1
//  DATA_W  16  operand width (FP16: 1 sign, 5 exponent, 10 mantissa)
//  AW      $clog2(DEPTH)  buffer address width, derived (localparam)
// PORTS
//  clk       in   1       clock
//  reset     in   1       asynchronous, active-high reset
//  wr_en     in   1       buffer write strobe
//  wr_addr   in   AW      buffer write address
//  wr_a      in   DATA_W  A operand to write
//  wr_b      in   DATA_W  B operand to write
//  go        in   1       start streaming (1-cycle pulse)
//  len       in   AW+1    number of elements to stream
//  busy      out  1       streaming in progress
//  done      out  1       1-cycle pulse: vector completed
//  elem_idx  out  AW      index of the element currently issued
//  pe_start  out  1       operand-valid / enable to processing unit
//  pe_a      out  DATA_W  A operand to processing unit
//  pe_b      out  DATA_W  B operand to processing unit
//  pe_ready  in   1       processing unit output P valid (accumulate finished)
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, pe_start=0, pe_a=0, pe_b=0, elem_idx=0; buffer contents not cleared.
//  Asserting reset mid-stream aborts immediately. No done pulse is produced.
//  FSM states IDLE, ISSUE, GAP, FIN:
//  - IDLE:
//    - go=1 and len!=0: latch len_q=min(len,DEPTH), idx=0, go to ISSUE.
//    - go=1 and len=0: go to FIN directly.
//  - ISSUE:
//    - pe_start=1; pe_a/pe_b = buffer[idx], held stable.
//    - Stay in ISSUE until pe_ready=1 is sampled, then go to GAP.
//  - GAP:
//    - pe_start=0 for exactly one cycle; idx increments.
//    - If idx+1==len_q go to FIN, else go to ISSUE.
//  - FIN: done=1 for one cycle, then go to IDLE.
//  Outputs:
//  - busy=1 in ISSUE and GAP only.
//  - elem_idx=idx.
//  - pe_a/pe_b keep their last value outside ISSUE.
//  Latency: go sampled at edge N gives pe_start=1 with buffer[0] after edge N+1.
//  pe_ready is ignored outside ISSUE.
//  If pe_ready=1 on the first ISSUE cycle, ISSUE lasts one cycle.
//  go while busy or in FIN: ignored.
//  Writes:
//  - wr_en while busy: ignored, buffer unchanged.
//  - wr_en in IDLE/FIN: buffer[wr_addr] <= {wr_a,wr_b} at the edge.
//  - wr_addr >= DEPTH: write dropped.
//  - go and wr_en in the same IDLE cycle: the write lands; element 0 reads the post-write value.
//  The index never wraps: termination is idx==len_q-1 at GAP.
// CONFIGURATION
//  Macro FEEDER_ZERO_SKIP_EN:
//  - Defined: any element with A or B equal to +/-0 (bits[14:0]==0) is skipped with no ISSUE and no pe_start.
//    - The skip costs one GAP cycle.
//    - If every remaining element is zero, go straight to FIN.
//    - Extra output skip_cnt [AW+1] counts skipped elements; it clears on go.
//  - Undefined: every element is issued, and the skip_cnt port does not exist.
// STRUCTURE
//  Package ttpu_pkg:
//  - typedef logic [15:0] fp16_t
//  - typedef enum {IDLE,ISSUE,GAP,FIN} feeder_state_t
//  - function fp16_is_zero(fp16_t)
//  Sub-module feeder_operand_buf:
//  - DEPTH x 2*DATA_W register file.
//  - One synchronous write port, one combinational read port.
//  - The write-enable gate for busy stays in the parent.
// TESTING
//  1. Write A={1.0,2.0,3.0} (16'h3C00,16'h4000,16'h4200) and B=all 1.0; go with len=3; PE model gives ready 6 cycles after start.
//     -> 3 ISSUE windows with the correct pe_a, one-cycle gaps, a single done pulse, busy low after it.
//  2. go with len=0 -> done one cycle later, pe_start never asserted, busy stays 0.
//  3. go with len=12, DEPTH=8 -> exactly 8 elements issued, then done.
//  4. wr_en to addr 1 during element 0 of a stream -> stream uses the old value, and a readback after done shows the old value.
//     Also: go pulsed while busy -> no restart.
//  5. reset asserted while in ISSUE for element 1 -> next cycle pe_start=0, busy=0, no done.
//     A new go then streams from element 0.
//  6. FEEDER_ZERO_SKIP_EN with A={1.0,16'h8000,2.0} and len=3 -> 2 ISSUE windows (idx 0,2), skip_cnt=1, done.
//     Without the macro: 3 ISSUE windows.

Source files
------------

// File: rtl/ttpu_pkg.sv
// Shared types for the FP16 tile processing unit: operand type, feeder FSM states
// and the signed-zero test used by the optional zero-skip path.
package ttpu_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        FIN
    } feeder_state_t;

    // +0 and -0 both count as zero: only the sign bit may be set.
    function automatic logic fp16_is_zero(input fp16_t v);
        return (v[14:0] == 15'd0);
    endfunction

endpackage

// File: rtl/feeder_operand_buf.sv
// Operand pair register file for the MAC feeder: DEPTH entries of {A,B},
// one synchronous write port and one combinational read port.
module feeder_operand_buf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [2*DATA_W-1:0] mem_q [DEPTH];

    // Contents survive reset; out-of-range writes are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_q[wr_addr] <= {wr_a, wr_b};
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (int'(rd_addr) < DEPTH) begin
            rd_a = mem_q[rd_addr][2*DATA_W-1:DATA_W];
            rd_b = mem_q[rd_addr][DATA_W-1:0];
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams a buffered FP16 operand vector into the MAC unit via pe_start/pe_ready.
// Optional macro FEEDER_ZERO_SKIP_EN skips elements whose A or B is +/-0 and adds skip_cnt.
module mac_operand_feeder
    import ttpu_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = 16,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic              go,
    input  logic [AW:0]       len,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     elem_idx,
    output logic              pe_start,
    output logic [DATA_W-1:0] pe_a,
    output logic [DATA_W-1:0] pe_b,
    input  logic              pe_ready,
`ifdef FEEDER_ZERO_SKIP_EN
    output logic [AW:0]       skip_cnt,
`endif
    output feeder_state_t     dbg_state_o
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    feeder_state_t     state_q;
    logic [AW-1:0]     idx_q;
    logic [AW:0]       len_q;
    logic              busy_q;
    logic              done_q;
    logic              pe_start_q;
    logic [DATA_W-1:0] pe_a_q;
    logic [DATA_W-1:0] pe_b_q;
`ifdef FEEDER_ZERO_SKIP_EN
    logic [AW:0]       skip_cnt_q;
`endif

    logic              buf_we;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [AW:0]       nxt_idx;
    logic [AW:0]       len_clamped;
    logic              elem_skip;

    // Writes are only accepted while no vector is in flight.
    assign buf_we      = wr_en && ((state_q == IDLE) || (state_q == FIN));
    // GAP looks ahead at the element it is about to issue; ISSUE loads its own.
    assign rd_addr     = (state_q == GAP) ? idx_q + 1'b1 : idx_q;
    assign nxt_idx     = {1'b0, idx_q} + 1'b1;
    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

`ifdef FEEDER_ZERO_SKIP_EN
    assign elem_skip = fp16_is_zero(rd_a) || fp16_is_zero(rd_b);
    assign skip_cnt  = skip_cnt_q;
`else
    assign elem_skip = 1'b0;
`endif

    feeder_operand_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .rd_addr (rd_addr),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // The first ISSUE cycle after go is a load cycle (pe_start still low), so a
    // write landing together with go is visible in element 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pe_start_q <= 1'b0;
            pe_a_q     <= '0;
            pe_b_q     <= '0;
`ifdef FEEDER_ZERO_SKIP_EN
            skip_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        idx_q <= '0;
`ifdef FEEDER_ZERO_SKIP_EN
                        skip_cnt_q <= '0;
`endif
                        if (len != '0) begin
                            len_q   <= len_clamped;
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                ISSUE: begin
                    if (!pe_start_q) begin
                        if (elem_skip) begin
`ifdef FEEDER_ZERO_SKIP_EN
                            skip_cnt_q <= skip_cnt_q + 1'b1;
`endif
                            state_q <= GAP;
                        end else begin
                            pe_start_q <= 1'b1;
                            pe_a_q     <= rd_a;
                            pe_b_q     <= rd_b;
                        end
                    end else if (pe_ready) begin
                        pe_start_q <= 1'b0;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    if (nxt_idx == len_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        // A skipped element stays in GAP for one cycle and never raises pe_start.
                        if (elem_skip) begin
`ifdef FEEDER_ZERO_SKIP_EN
                            skip_cnt_q <= skip_cnt_q + 1'b1;
`endif
                        end else begin
                            pe_start_q <= 1'b1;
                            pe_a_q     <= rd_a;
                            pe_b_q     <= rd_b;
                            state_q    <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign elem_idx    = idx_q;
    assign pe_start    = pe_start_q;
    assign pe_a        = pe_a_q;
    assign pe_b        = pe_b_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: PE ready model, scoreboard of issued operand pairs,
// one task per scenario and a final pass/total report.
module tb_mac_operand_feeder;
    import ttpu_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_b;
    logic              go;
    logic [AW:0]       len;
    logic              busy;
    logic              done;
    logic [AW-1:0]     elem_idx;
    logic              pe_start;
    logic [DATA_W-1:0] pe_a;
    logic [DATA_W-1:0] pe_b;
    logic              pe_ready;
`ifdef FEEDER_ZERO_SKIP_EN
    logic [AW:0]       skip_cnt;
`endif
    feeder_state_t     dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int win_cnt  = 0;
    int done_cnt = 0;
    int gap_len  = 0;
    int stab_err = 0;
    int pe_lat   = 6;
    int st_cnt   = 0;
    bit check_gap  = 1'b0;
    bit prev_start = 1'b0;
    logic [DATA_W-1:0] hold_a, hold_b;
    logic [15:0] mdl_a [DEPTH];
    logic [15:0] mdl_b [DEPTH];
    logic [2*DATA_W+AW-1:0] exp_q[$];

    mac_operand_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_a        (wr_a),
        .wr_b        (wr_b),
        .go          (go),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .elem_idx    (elem_idx),
        .pe_start    (pe_start),
        .pe_a        (pe_a),
        .pe_b        (pe_b),
        .pe_ready    (pe_ready),
`ifdef FEEDER_ZERO_SKIP_EN
        .skip_cnt    (skip_cnt),
`endif
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // PE model: raise ready in the pe_lat-th cycle of a pe_start window
    always @(negedge clk) begin
        if (pe_start && !pe_ready) begin
            st_cnt++;
            pe_ready = (st_cnt >= pe_lat);
        end else begin
            st_cnt   = 0;
            pe_ready = 1'b0;
        end
    end

    // Scoreboard monitor: each rising pe_start pops one expected {a,b,idx}
    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
            gap_len    = 0;
        end else begin
            if (pe_start && !prev_start) begin
                if (check_gap && win_cnt > 0) begin
                    chk_cnt++;
                    if (gap_len !== 1) $display("FAIL gap_len: got %0d expected 1", gap_len);
                    else pass_cnt++;
                end
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_issue: got a=%h idx=%0d expected no issue", pe_a, elem_idx);
                end else begin
                    logic [2*DATA_W+AW-1:0] e;
                    e = exp_q.pop_front();
                    if ({pe_a, pe_b, elem_idx} !== e)
                        $display("FAIL issue_data: got a=%h b=%h idx=%0d expected a=%h b=%h idx=%0d",
                                 pe_a, pe_b, elem_idx, e[2*DATA_W+AW-1:DATA_W+AW], e[DATA_W+AW-1:AW], e[AW-1:0]);
                    else pass_cnt++;
                end
                win_cnt++;
                gap_len = 0;
                hold_a  = pe_a;
                hold_b  = pe_b;
            end else if (pe_start) begin
                if (pe_a !== hold_a || pe_b !== hold_b) stab_err++;
            end else begin
                gap_len++;
            end
            if (done === 1'b1) done_cnt++;
            prev_start = pe_start;
        end
    end

    // Driver tasks
    task automatic write_elem(input int addr, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr[AW-1:0]; wr_a = a; wr_b = b;
        if (addr < DEPTH) begin mdl_a[addr] = a; mdl_b[addr] = b; end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_stream(input int n, input bit do_wr, input int wa,
                                input logic [15:0] a, input logic [15:0] b);
        int eff;
        @(negedge clk);
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = wa[AW-1:0]; wr_a = a; wr_b = b;
            if (wa < DEPTH) begin mdl_a[wa] = a; mdl_b[wa] = b; end
        end
        eff = (n > DEPTH) ? DEPTH : n;
        win_cnt = 0; done_cnt = 0; gap_len = 0; stab_err = 0;
        for (int i = 0; i < eff; i++) begin
`ifdef FEEDER_ZERO_SKIP_EN
            if (mdl_a[i][14:0] == 15'd0 || mdl_b[i][14:0] == 15'd0) continue;
`endif
            exp_q.push_back({mdl_a[i], mdl_b[i], i[AW-1:0]});
        end
        go = 1'b1; len = n[AW:0];
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (pe_start !== 1'b0) $display("FAIL reset_pe_start: got %b expected 0", pe_start); else pass_cnt++;
        chk_cnt++; if ({pe_a, pe_b} !== 32'h0) $display("FAIL reset_pe_ab: got %h expected 0", {pe_a, pe_b}); else pass_cnt++;
        chk_cnt++; if (elem_idx !== '0) $display("FAIL reset_idx: got %0d expected 0", elem_idx); else pass_cnt++;
        chk_cnt++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected IDLE", dbg_state); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic_stream();
        bit seen;
        write_elem(0, 16'h3C00, 16'h3C00);
        write_elem(1, 16'h4000, 16'h3C00);
        write_elem(2, 16'h4200, 16'h3C00);
        pe_lat = 6; check_gap = 1'b1;
        start_stream(3, 1'b0, 0, 16'h0, 16'h0);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_go: got %b expected 1", busy); else pass_cnt++;
        chk_cnt++; if (pe_start !== 1'b0) $display("FAIL basic_load_cycle: got %b expected 0", pe_start); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (pe_start !== 1'b1 || pe_a !== 16'h3C00)
            $display("FAIL basic_first_issue: got start=%b a=%h expected 1 3c00", pe_start, pe_a); else pass_cnt++;
        wait_done(80, seen);
        chk_cnt++; if (!seen) $display("FAIL basic_done_timeout: got no done expected done"); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", done); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (win_cnt != 3) $display("FAIL basic_windows: got %0d expected 3", win_cnt); else pass_cnt++;
        chk_cnt++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
        chk_cnt++; if (stab_err != 0) $display("FAIL basic_stability: got %0d expected 0", stab_err); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL basic_leftover: got %0d expected 0", exp_q.size()); else pass_cnt++;
        check_gap = 1'b0;
    endtask

    task automatic test_len_zero();
        int busy_cycles = 0;
        start_stream(0, 1'b0, 0, 16'h0, 16'h0);
        chk_cnt++; if (done !== 1'b1) $display("FAIL zero_len_done: got %b expected 1", done); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (busy === 1'b1 || pe_start === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        chk_cnt++; if (busy_cycles != 0) $display("FAIL zero_len_busy: got %0d expected 0", busy_cycles); else pass_cnt++;
        chk_cnt++; if (win_cnt != 0) $display("FAIL zero_len_windows: got %0d expected 0", win_cnt); else pass_cnt++;
        chk_cnt++; if (done_cnt != 1) $display("FAIL zero_len_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_len_clamp();
        bit seen;
        for (int i = 0; i < DEPTH; i++)
            write_elem(i, 16'($urandom_range(1, 16'h7BFF)), 16'($urandom_range(1, 16'h7BFF)));
        pe_lat = $urandom_range(1, 3);
        start_stream(12, 1'b0, 0, 16'h0, 16'h0);
        wait_done(200, seen);
        chk_cnt++; if (!seen) $display("FAIL clamp_done_timeout: got no done expected done"); else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++; if (win_cnt != DEPTH) $display("FAIL clamp_windows: got %0d expected %0d", win_cnt, DEPTH); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL clamp_leftover: got %0d expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_write_while_busy();
        bit seen;
        bit found = 1'b0;
        write_elem(0, 16'h4400, 16'h3C00);
        write_elem(1, 16'h4500, 16'h4000);
        pe_lat = 4;
        start_stream(2, 1'b0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (pe_start === 1'b1) found = 1'b1;
        end
        chk_cnt++; if (!found) $display("FAIL busy_wr_no_issue: got no pe_start expected pe_start"); else pass_cnt++;
        wr_en = 1'b1; wr_addr = 3'd1; wr_a = 16'h7777; wr_b = 16'h1111;
        go = 1'b1; len = 4'd5;
        @(negedge clk);
        wr_en = 1'b0; go = 1'b0;
        wait_done(60, seen);
        chk_cnt++; if (!seen) $display("FAIL busy_wr_done_timeout: got no done expected done"); else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++; if (win_cnt != 2) $display("FAIL busy_go_windows: got %0d expected 2", win_cnt); else pass_cnt++;
        chk_cnt++; if (done_cnt != 1) $display("FAIL busy_go_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
        // Readback stream; also lands a write to element 0 together with go.
        start_stream(2, 1'b1, 0, 16'h4600, 16'h3C00);
        wait_done(60, seen);
        chk_cnt++; if (!seen) $display("FAIL readback_done_timeout: got no done expected done"); else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++; if (win_cnt != 2) $display("FAIL readback_windows: got %0d expected 2", win_cnt); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL readback_leftover: got %0d expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        bit seen;
        bit found = 1'b0;
        for (int i = 0; i < 4; i++) write_elem(i, 16'h3C00 + 16'(i), 16'h4000 + 16'(i));
        pe_lat = 5;
        start_stream(4, 1'b0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (pe_start === 1'b1 && elem_idx === 3'd1) found = 1'b1;
        end
        chk_cnt++; if (!found) $display("FAIL rst_mid_no_elem1: got no issue of idx 1 expected issue"); else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++; if (pe_start !== 1'b0) $display("FAIL rst_mid_pe_start: got %b expected 0", pe_start); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (dbg_state !== IDLE) $display("FAIL rst_mid_state: got %0d expected IDLE", dbg_state); else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt++; if (done_cnt != 0) $display("FAIL rst_mid_done: got %0d expected 0", done_cnt); else pass_cnt++;
        start_stream(2, 1'b0, 0, 16'h0, 16'h0);
        wait_done(60, seen);
        chk_cnt++; if (!seen) $display("FAIL rst_restart_timeout: got no done expected done"); else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++; if (win_cnt != 2) $display("FAIL rst_restart_windows: got %0d expected 2", win_cnt); else pass_cnt++;
    endtask

    task automatic test_zero_skip();
        bit seen;
        write_elem(0, 16'h3C00, 16'h3C00);
        write_elem(1, 16'h8000, 16'h3C00);
        write_elem(2, 16'h4000, 16'h3C00);
        pe_lat = 3;
        start_stream(3, 1'b0, 0, 16'h0, 16'h0);
        wait_done(60, seen);
        chk_cnt++; if (!seen) $display("FAIL skip_done_timeout: got no done expected done"); else pass_cnt++;
        repeat (2) @(negedge clk);
`ifdef FEEDER_ZERO_SKIP_EN
        chk_cnt++; if (win_cnt != 2) $display("FAIL skip_windows: got %0d expected 2", win_cnt); else pass_cnt++;
        chk_cnt++; if (skip_cnt !== 4'd1) $display("FAIL skip_cnt: got %0d expected 1", skip_cnt); else pass_cnt++;
`else
        chk_cnt++; if (win_cnt != 3) $display("FAIL noskip_windows: got %0d expected 3", win_cnt); else pass_cnt++;
`endif
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL skip_leftover: got %0d expected 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        go = 1'b0; len = '0; pe_ready = 1'b0;
        test_reset();
        test_basic_stream();
        test_len_zero();
        test_len_clamp();
        test_write_while_busy();
        test_reset_mid_stream();
        test_zero_skip();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
